uart_rx_frontend: RTL

//  Serial receive front end of ecap5_dwbuart. Oversamples uart_rx_i at 16x baud using a phase-accumulator tick.

---
 rtl/ecap5_dwbuart_pkg.sv | 52 +++++
 rtl/uart_baud_gen.sv | 35 +++
 rtl/uart_rx_frontend.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ecap5_dwbuart_pkg.sv
// rtl/ecap5_dwbuart_pkg.sv - shared UART types, encodings and helpers
// Contents:
//   rx_state_t      receive deframer states
//   DS_5..DS_8      data size encodings (CR.DS)
//   PARITY_*        parity encodings (CR.P): [1]=enable, [0]=odd
//   SAMPLE_*/BIT_LAST  oversampling counter positions
//   maj3()          2-of-3 majority vote
//   data_last_idx() index of the last data bit for a data size
package ecap5_dwbuart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [1:0] DS_5 = 2'd0;
  localparam logic [1:0] DS_6 = 2'd1;
  localparam logic [1:0] DS_7 = 2'd2;
  localparam logic [1:0] DS_8 = 2'd3;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b10;
  localparam logic [1:0] PARITY_ODD  = 2'b11;
  localparam int         PAR_EN_BIT  = 1;
  localparam int         PAR_ODD_BIT = 0;

  // Samples are taken around the middle of each 16-tick bit period.
  localparam logic [3:0] SAMPLE_FIRST = 4'd7;
  localparam logic [3:0] SAMPLE_MID   = 4'd8;
  localparam logic [3:0] SAMPLE_LAST  = 4'd9;
  localparam logic [3:0] BIT_LAST     = 4'd15;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  function automatic logic [2:0] data_last_idx(input logic [1:0] ds);
    logic [2:0] idx;
    case (ds)
      DS_5:    idx = 3'd4;
      DS_6:    idx = 3'd5;
      DS_7:    idx = 3'd6;
      DS_8:    idx = 3'd7;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - phase-accumulator 16x baud tick generator
// Ports:
//   clk_i   in   system clock
//   rst_i   in   asynchronous active-high reset
//   incr_i  in   accumulator increment; tick rate = f_clk*incr_i/2^ACC_WIDTH
//   tick_o  out  one-cycle pulse on accumulator carry-out
module uart_baud_gen #(
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ACC_WIDTH-1:0] incr_i,
  output logic                 tick_o
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH:0]   sum;

  // Free-running: the accumulator is never cleared, so the tick phase is
  // independent of frame boundaries.
  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, incr_i};
    acc_d  = sum[ACC_WIDTH-1:0];
    tick_o = sum[ACC_WIDTH];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// rtl/uart_rx_frontend.sv - UART receive deframer with 16x oversampling
// Ports:
//   clk_i         in   system clock
//   rst_i         in   asynchronous active-high reset
//   uart_rx_i     in   asynchronous serial line, idle high
//   acc_incr_i    in   baud accumulator increment (16x baud tick)
//   ds_i          in   data size: 0=5 .. 3=8 bits
//   s_i           in   stop bits: 0=one, 1=two
//   p_i           in   [1]=parity enable, [0]=odd/even
//   frame_o       out  received data, right-justified
//   parity_err_o  out  parity mismatch for frame_o
//   frame_err_o   out  a stop bit was sampled low
//   valid_o       out  one-cycle pulse when frame_o/flags update
module uart_rx_frontend
  import ecap5_dwbuart_pkg::*;
#(
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 uart_rx_i,
  input  logic [ACC_WIDTH-1:0] acc_incr_i,
  input  logic [1:0]           ds_i,
  input  logic                 s_i,
  input  logic [1:0]           p_i,
  output logic [7:0]           frame_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 valid_o
);

  logic tick;

  uart_baud_gen #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_baud_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .incr_i (acc_incr_i),
    .tick_o (tick)
  );

  rx_state_t  state_q, state_d;
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       rx_prev_q, rx_prev_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] samp_q, samp_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] data_q, data_d;
  logic [1:0] ds_q, ds_d;
  logic       s_q, s_d;
  logic [1:0] p_q, p_d;
  logic       stop_idx_q, stop_idx_d;
  logic       pe_acc_q, pe_acc_d;
  logic       fe_acc_q, fe_acc_d;
  logic [7:0] frame_q, frame_d;
  logic       pe_q, pe_d;
  logic       fe_q, fe_d;
  logic       valid_q, valid_d;

  logic rx_s;
  logic fall;
  logic bit_end;
  logic mid_end;
  logic maj_full;
  logic maj_mid;

  always_comb begin
    rx_s    = sync2_q;
    fall    = rx_prev_q & ~rx_s;
    bit_end = tick && (cnt_q == BIT_LAST);
    mid_end = tick && (cnt_q == SAMPLE_LAST);
    // At mid-bit completion the third sample is the one arriving this cycle.
    maj_full = maj3(samp_q);
    maj_mid  = maj3({rx_s, samp_q[1:0]});

    sync1_d    = uart_rx_i;
    sync2_d    = sync1_q;
    rx_prev_d  = sync2_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    samp_d     = samp_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    ds_d       = ds_q;
    s_d        = s_q;
    p_d        = p_q;
    stop_idx_d = stop_idx_q;
    pe_acc_d   = pe_acc_q;
    fe_acc_d   = fe_acc_q;
    frame_d    = frame_q;
    pe_d       = pe_q;
    fe_d       = fe_q;
    valid_d    = 1'b0;

    if (tick) begin
      cnt_d = cnt_q + 4'd1;
      case (cnt_q)
        SAMPLE_FIRST: samp_d[0] = rx_s;
        SAMPLE_MID:   samp_d[1] = rx_s;
        SAMPLE_LAST:  samp_d[2] = rx_s;
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        // Edge-triggered so a line stuck low after a break never retriggers.
        if (fall) begin
          state_d    = START;
          cnt_d      = 4'd0;
          bit_idx_d  = 3'd0;
          data_d     = 8'd0;
          stop_idx_d = 1'b0;
          pe_acc_d   = 1'b0;
          fe_acc_d   = 1'b0;
          ds_d       = ds_i;
          s_d        = s_i;
          p_d        = p_i;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = maj_full ? IDLE : DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          data_d[bit_idx_q] = maj_full;
          if (bit_idx_q == data_last_idx(ds_q)) begin
            state_d = p_q[PAR_EN_BIT] ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          pe_acc_d = ((^data_q) ^ maj_full) != p_q[PAR_ODD_BIT];
          state_d  = STOP;
        end
      end
      STOP: begin
        if (stop_idx_q == s_q) begin
          // Last stop bit finishes mid-bit to leave margin for the next start.
          if (mid_end) begin
            frame_d = data_q;
            pe_d    = pe_acc_q;
            fe_d    = fe_acc_q | ~maj_mid;
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end else if (bit_end) begin
          fe_acc_d   = fe_acc_q | ~maj_full;
          stop_idx_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      cnt_q      <= 4'd0;
      samp_q     <= 3'd0;
      bit_idx_q  <= 3'd0;
      data_q     <= 8'd0;
      ds_q       <= 2'd0;
      s_q        <= 1'b0;
      p_q        <= 2'd0;
      stop_idx_q <= 1'b0;
      pe_acc_q   <= 1'b0;
      fe_acc_q   <= 1'b0;
      frame_q    <= 8'd0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      rx_prev_q  <= rx_prev_d;
      cnt_q      <= cnt_d;
      samp_q     <= samp_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      ds_q       <= ds_d;
      s_q        <= s_d;
      p_q        <= p_d;
      stop_idx_q <= stop_idx_d;
      pe_acc_q   <= pe_acc_d;
      fe_acc_q   <= fe_acc_d;
      frame_q    <= frame_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      valid_q    <= valid_d;
    end
  end

  assign frame_o      = frame_q;
  assign parity_err_o = pe_q;
  assign frame_err_o  = fe_q;
  assign valid_o      = valid_q;

endmodule
